// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states,
// the latched request record and small size/alignment helpers.
// Imported by memory_access_unit and mau_extend.
package memory_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int unsigned MEM_BYTES_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Request as captured at acceptance.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Number of bytes touched; the illegal encoding is faulted before use.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

    // Index of the final byte beat of a split access.
    function automatic logic [1:0] last_beat_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: last_beat_idx = 2'd0;
            SZ_HALF: last_beat_idx = 2'd1;
            default: last_beat_idx = 2'd3;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = |addr_lo;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_extend.sv
// Purpose: size-dependent sign/zero extension of assembled load data.
// Latency: combinational.  Backpressure: none (pure function).
// Ports: raw (assembled little-endian bytes), size, is_unsigned -> data (extended result).
module mau_extend
    import memory_access_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic sgn;
    assign sgn = ~is_unsigned;

    always_comb begin
        data = raw;
        case (size)
            SZ_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Purpose: single-outstanding load/store initiator onto a byte-addressed memory, splitting misaligned accesses.
// Latency: fault 1 cycle, aligned 2 cycles, split access nbytes+1 cycles from request acceptance.
// Backpressure: req_ready only in IDLE; response is held until resp_ready.
// Ports: clk/rst (sync, active-high); req_* request handshake; resp_* response handshake;
//        memory_* drive the memory, memory_data_out is its combinational read data.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = MEM_BYTES_DEFAULT,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        memory_write,
    output logic [31:0] memory_addr,
    output logic [1:0]  memory_size,
    output logic        memory_unsigned,
    output logic [31:0] memory_data_in,
    input  logic [31:0] memory_data_out
);

    state_t      state, state_nxt;
    req_t        req_q;
    logic        misaligned_q;
    logic [1:0]  beat_q;
    logic [31:0] asm_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        accept;
    logic [32:0] req_end;
    logic        req_misaligned;
    logic        req_fault;
    logic        last_beat;
    logic [31:0] asm_nxt;
    logic [31:0] ext_data;

    assign accept         = req_valid & req_ready;
    // 33-bit end address so a request near 2^32 cannot wrap into range.
    assign req_end        = {1'b0, req_addr} + {30'b0, size_nbytes(req_size)};
    assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign req_fault      = (req_size == SZ_ILLEGAL)
                          | (req_end > 33'(MEM_BYTES))
                          | (req_misaligned & ~SPLIT_MISALIGNED);

    assign last_beat = ~misaligned_q | (beat_q == last_beat_idx(req_q.size));

    // Split accesses return one byte per beat in the low lane; merge it into
    // its final byte position. Aligned accesses take the memory word as is.
    always_comb begin
        asm_nxt = memory_data_out;
        if (misaligned_q) begin
            asm_nxt = asm_q;
            asm_nxt[{beat_q, 3'b000} +: 8] = memory_data_out[7:0];
        end
    end

    mau_extend u_extend (
        .raw         (asm_nxt),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .data        (ext_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = req_fault ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (last_beat) state_nxt = ST_RESP;
            ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, beat sequencing and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= '0;
            misaligned_q <= 1'b0;
            beat_q       <= 2'd0;
            asm_q        <= '0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q.write       <= req_write;
                        req_q.size        <= req_size;
                        req_q.is_unsigned <= req_unsigned;
                        req_q.addr        <= req_addr;
                        req_q.wdata       <= req_wdata;
                        misaligned_q      <= req_misaligned;
                        beat_q            <= 2'd0;
                        asm_q             <= '0;
                        rdata_q           <= '0;
                        fault_q           <= req_fault;
                    end
                end
                ST_ACCESS: begin
                    asm_q  <= asm_nxt;
                    beat_q <= beat_q + 2'd1;
                    if (last_beat) begin
                        rdata_q <= req_q.write ? 32'd0 : ext_data;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
                        fault_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    // Extension is done here, so the memory is always asked for raw bytes.
    assign memory_unsigned = 1'b1;

    always_comb begin
        memory_write   = 1'b0;
        memory_addr    = '0;
        memory_size    = SZ_WORD;
        memory_data_in = '0;
        if (state == ST_ACCESS) begin
            memory_write = req_q.write;
            if (misaligned_q) begin
                memory_addr    = req_q.addr + {30'b0, beat_q};
                memory_size    = SZ_BYTE;
                memory_data_in = {24'b0, req_q.wdata[{beat_q, 3'b000} +: 8]};
            end else begin
                memory_addr    = req_q.addr;
                memory_size    = req_q.size;
                memory_data_in = req_q.wdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    // ---------------- DUT with splitting enabled ----------------
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        memory_write, memory_unsigned;
    logic [31:0] memory_addr, memory_data_in, memory_data_out;
    logic [1:0]  memory_size;

    memory_access_unit #(.MEM_BYTES(4096), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .memory_write(memory_write), .memory_addr(memory_addr), .memory_size(memory_size),
        .memory_unsigned(memory_unsigned), .memory_data_in(memory_data_in),
        .memory_data_out(memory_data_out)
    );

    // ---------------- DUT with misaligned -> fault ----------------
    logic        n_req_valid = 1'b0, n_req_write = 1'b0, n_req_unsigned = 1'b0, n_resp_ready = 1'b1;
    logic [1:0]  n_req_size = 2'b00;
    logic [31:0] n_req_addr = '0, n_req_wdata = '0;
    logic        n_req_ready, n_resp_valid, n_resp_fault;
    logic [31:0] n_resp_rdata;
    logic        n_memory_write, n_memory_unsigned;
    logic [31:0] n_memory_addr, n_memory_data_in;
    logic [31:0] n_memory_data_out = 32'h1234_5678;
    logic [1:0]  n_memory_size;
    int          n_wr_count = 0;

    memory_access_unit #(.MEM_BYTES(4096), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
        .req_size(n_req_size), .req_unsigned(n_req_unsigned), .req_addr(n_req_addr),
        .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
        .resp_rdata(n_resp_rdata), .resp_fault(n_resp_fault),
        .memory_write(n_memory_write), .memory_addr(n_memory_addr), .memory_size(n_memory_size),
        .memory_unsigned(n_memory_unsigned), .memory_data_in(n_memory_data_in),
        .memory_data_out(n_memory_data_out)
    );

    always @(posedge clk) if (n_memory_write) n_wr_count <= n_wr_count + 1;

    // ---------------- memory model (little-endian, combinational read) ----------------
    logic [7:0]  mem [0:4095];
    logic [11:0] mem_a;
    assign mem_a = memory_addr[11:0];

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    always_comb begin
        memory_data_out = '0;
        case (memory_size)
            2'b00:   memory_data_out = {24'b0, mem[mem_a]};
            2'b01:   memory_data_out = {16'b0, mem[mem_a + 12'd1], mem[mem_a]};
            default: memory_data_out = {mem[mem_a + 12'd3], mem[mem_a + 12'd2],
                                        mem[mem_a + 12'd1], mem[mem_a]};
        endcase
    end

    always @(posedge clk) begin
        if (memory_write) begin
            wr_log.push_back('{memory_addr, memory_size, memory_data_in});
            mem[mem_a] <= memory_data_in[7:0];
            if (memory_size != 2'b00) mem[mem_a + 12'd1] <= memory_data_in[15:8];
            if (memory_size == 2'b10) begin
                mem[mem_a + 12'd2] <= memory_data_in[23:16];
                mem[mem_a + 12'd3] <= memory_data_in[31:24];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          t_acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard monitor: compares each new response against the oldest expectation.
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (resp_valid) begin
            if (!seen) begin
                exp_t e;
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h fault %0b with nothing expected",
                             resp_rdata, resp_fault);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_rdata"}, resp_rdata, e.rdata);
                    check({e.name, "_fault"}, 32'(resp_fault), 32'(e.fault));
                    check({e.name, "_latency"}, 32'(cyc - e.t_acc), 32'(e.lat));
                end
            end
            if (resp_ready) seen = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ef, input int el, input bit expect_resp);
        bit done;
        exp_t e;
        @(posedge clk); #1;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                if (expect_resp) begin
                    e.name = name; e.rdata = er; e.fault = ef; e.t_acc = cyc; e.lat = el;
                    exp_q.push_back(e);
                end
            end
        end
        if (!done) begin
            n_tot++;
            $display("FAIL %s_accept: req_ready never seen high", name);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready && !resp_valid) done = 1'b1;
        end
        if (!done) begin
            n_tot++;
            $display("FAIL %s_drain: response not completed, %0d pending", name, exp_q.size());
        end
    endtask

    task automatic op(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ef, input int el);
        issue(name, wr, sz, uns, addr, wdata, er, ef, el, 1'b1);
        wait_idle(name);
    endtask

    task automatic n_op(input string name, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] er, input logic ef, input int el);
        int t;
        bit got;
        @(posedge clk); #1;
        n_req_write = 1'b0; n_req_size = sz; n_req_unsigned = 1'b0; n_req_addr = addr;
        n_req_valid = 1'b1;
        @(negedge clk);
        t = cyc;
        check({name, "_req_ready"}, 32'(n_req_ready), 32'd1);
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (n_resp_valid) got = 1'b1;
        end
        if (!got) begin
            n_tot++;
            $display("FAIL %s_timeout: no response within 20 cycles", name);
        end else begin
            check({name, "_latency"}, 32'(cyc - t), 32'(el));
            check({name, "_fault"}, 32'(n_resp_fault), 32'(ef));
            check({name, "_rdata"}, n_resp_rdata, er);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        bit got;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",   32'(req_ready), 32'd1);
        check("rst_resp_valid",  32'(resp_valid), 32'd0);
        check("rst_resp_fault",  32'(resp_fault), 32'd0);
        check("rst_resp_rdata",  resp_rdata, 32'd0);
        check("rst_mem_write",   32'(memory_write), 32'd0);
        check("rst_mem_addr",    memory_addr, 32'd0);
        check("rst_mem_size",    32'(memory_size), 32'd2);
        check("rst_mem_unsigned", 32'(memory_unsigned), 32'd1);
        check("rst_mem_data_in", memory_data_in, 32'd0);

        // 1: aligned word store/load
        base = wr_log.size();
        op("st_w100", 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("st_w100_pulses", 32'(wr_log.size() - base), 32'd1);
        if (wr_log.size() > base) begin
            check("st_w100_addr", wr_log[base].addr, 32'h100);
            check("st_w100_size", 32'(wr_log[base].size), 32'd2);
            check("st_w100_data", wr_log[base].data, 32'hDEAD_BEEF);
        end
        op("ld_w100", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // 2: extension of byte/half loads
        op("ld_bs100", 1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFEF, 1'b0, 2);
        op("ld_bu100", 1'b0, SZ_BYTE, 1'b1, 32'h100, 32'h0, 32'h0000_00EF, 1'b0, 2);
        op("ld_hs100", 1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0, 32'hFFFF_BEEF, 1'b0, 2);

        // 3: misaligned half store split into two byte writes
        base = wr_log.size();
        op("st_h103", 1'b1, SZ_HALF, 1'b0, 32'h103, 32'h0000_A55A, 32'h0, 1'b0, 3);
        check("st_h103_pulses", 32'(wr_log.size() - base), 32'd2);
        if (wr_log.size() >= base + 2) begin
            check("st_h103_b0_addr", wr_log[base].addr, 32'h103);
            check("st_h103_b0_size", 32'(wr_log[base].size), 32'd0);
            check("st_h103_b0_data", wr_log[base].data, 32'h5A);
            check("st_h103_b1_addr", wr_log[base+1].addr, 32'h104);
            check("st_h103_b1_data", wr_log[base+1].data, 32'hA5);
        end
        op("ld_hs103", 1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0, 32'hFFFF_A55A, 1'b0, 3);
        op("ld_hu103", 1'b0, SZ_HALF, 1'b1, 32'h103, 32'h0, 32'h0000_A55A, 1'b0, 3);
        op("ld_w100b", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h5AAD_BEEF, 1'b0, 2);
        op("ld_w101",  1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'hA55A_ADBE, 1'b0, 5);
        op("ld_bs104", 1'b0, SZ_BYTE, 1'b0, 32'h104, 32'h0, 32'hFFFF_FFA5, 1'b0, 2);

        // 4: no-split instance faults on misalignment without touching memory
        n_op("ns_ld_w102", SZ_WORD, 32'h102, 32'h0, 1'b1, 1);
        n_op("ns_ld_w100", SZ_WORD, 32'h100, 32'h1234_5678, 1'b0, 2);
        check("ns_write_pulses", 32'(n_wr_count), 32'd0);

        // 5: range and size faults
        base = wr_log.size();
        op("ld_wFFE",  1'b0, SZ_WORD, 1'b0, 32'hFFE, 32'h0, 32'h0, 1'b1, 1);
        op("st_sz11",  1'b1, SZ_ILLEGAL, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        op("ld_hFFF",  1'b0, SZ_HALF, 1'b0, 32'hFFF, 32'h0, 32'h0, 1'b1, 1);
        op("ld_wtop",  1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1);
        check("fault_pulses", 32'(wr_log.size() - base), 32'd0);
        check("fault_mem10", 32'(mem[12'h010]), 32'h0);
        op("ld_wFFC",  1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0, 2);
        op("st_bFFF",  1'b1, SZ_BYTE, 1'b0, 32'hFFF, 32'h0000_0077, 32'h0, 1'b0, 2);
        op("ld_buFFF", 1'b0, SZ_BYTE, 1'b1, 32'hFFF, 32'h0, 32'h0000_0077, 1'b0, 2);

        // 6a: response stall holds resp_* and blocks new requests
        @(posedge clk); #1 resp_ready = 1'b0;
        issue("ld_stall", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h5AAD_BEEF, 1'b0, 2, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            n_tot++;
            $display("FAIL stall_timeout: resp_valid never rose");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_resp_valid", 32'(resp_valid), 32'd1);
            check("stall_resp_rdata", resp_rdata, 32'h5AAD_BEEF);
            check("stall_req_ready",  32'(req_ready), 32'd0);
        end
        // request raised in the same cycle as resp_ready must wait for IDLE
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_write = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b1; req_addr = 32'h101;
        req_valid = 1'b1;
        @(negedge clk);
        check("resp_cycle_req_ready", 32'(req_ready), 32'd0);
        op("ld_bu101", 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h0000_00BE, 1'b0, 2);

        // 6b: reset after the first beat of a split word store
        base = wr_log.size();
        issue("st_w201_rst", 1'b1, SZ_WORD, 1'b0, 32'h201, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready",  32'(req_ready), 32'd1);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_mem_write",  32'(memory_write), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_resp",    32'(resp_valid), 32'd0);
        check("rst_mid_pulses",     32'(wr_log.size() - base), 32'd1);
        check("rst_mid_mem201",     32'(mem[12'h201]), 32'h44);
        check("rst_mid_mem202",     32'(mem[12'h202]), 32'h00);
        op("ld_bu201", 1'b0, SZ_BYTE, 1'b1, 32'h201, 32'h0, 32'h0000_0044, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
